ps2_key_gen: RTL

Converts the raw PS/2 serial stream from a physical keyboard into the 11-bit toggle-strobed `ps2_key` event word consumed by the keyboard matrix block. It deserialises the PS/2 clock/data frames, checks framing and parity, and strips the E0, F0 and E1 prefix bytes. Each resulting make or break becomes exactly one `ps2_key` update. It sits between the keyboard pins and every consumer of `ps2_key`.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_rx_frame.sv | 99 +++++++++
 rtl/ps2_key_gen.sv | 85 ++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and decoder state type for the PS/2 keyboard receive path.
// Prefix and status byte values follow the scancode set 2 protocol.
package ps2_pkg;

    localparam logic [7:0] KEY_E0 = 8'hE0;
    localparam logic [7:0] KEY_F0 = 8'hF0;
    localparam logic [7:0] KEY_E1 = 8'hE1;

    localparam logic [7:0] KEY_AA = 8'hAA;
    localparam logic [7:0] KEY_FA = 8'hFA;
    localparam logic [7:0] KEY_FE = 8'hFE;
    localparam logic [7:0] KEY_EE = 8'hEE;
    localparam logic [7:0] KEY_00 = 8'h00;
    localparam logic [7:0] KEY_FF = 8'hFF;

    localparam logic [7:0] FAKE_SHIFT = 8'h12;
    localparam logic [2:0] PAUSE_LEN  = 3'd7;
    localparam logic [7:0] PAUSE_CODE = 8'h77;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREFIX,
        ST_PAUSE
    } dec_state_t;

    function automatic logic is_status(input logic [7:0] b);
        return (b == KEY_AA) || (b == KEY_FA) || (b == KEY_FE) || (b == KEY_EE);
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronise and deglitch the pins, shift in 11-bit frames,
// check start/parity/stop and abort stalled frames after TIMEOUT idle cycles.
module ps2_rx_frame #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_stb_o,
    output logic       frame_err_o
);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          fclk_q, fclk_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    byte_q, byte_d;
    logic          stb_q, stb_d, err_q, err_d;
    logic          fall;
    logic          frame_ok;

    assign fall = fclk_q && !clk_sync_q[1] && (flt_cnt_q == FW'(FILTER_LEN - 1));
    // shift_q holds {parity, D7..D0, start}; the stop bit is the live sample
    assign frame_ok = !shift_q[0] && (^shift_q[9:1]) && dat_sync_q[1];

    always_comb begin
        fclk_d    = fclk_q;
        flt_cnt_d = '0;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_d     = '0;
        byte_d    = byte_q;
        stb_d     = 1'b0;
        err_d     = 1'b0;
        if (clk_sync_q[1] != fclk_q) begin
            if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
                fclk_d = clk_sync_q[1];
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
        if (fall) begin
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = '0;
                byte_d    = shift_q[8:1];
                stb_d     = frame_ok;
                err_d     = !frame_ok;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                shift_d   = {dat_sync_q[1], shift_q[9:1]};
            end
        end else if (bit_cnt_q != '0) begin
            if (tmo_q == TW'(TIMEOUT - 1)) begin
                bit_cnt_d = '0;
                err_d     = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            fclk_q     <= 1'b1;
            flt_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tmo_q      <= '0;
            byte_q     <= '0;
            stb_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_data_i};
            fclk_q     <= fclk_d;
            flt_cnt_q  <= flt_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tmo_q      <= tmo_d;
            byte_q     <= byte_d;
            stb_q      <= stb_d;
            err_q      <= err_d;
        end
    end

    assign byte_o      = byte_q;
    assign byte_stb_o  = stb_q;
    assign frame_err_o = err_q;

endmodule

// File: rtl/ps2_key_gen.sv
// PS/2 keyboard to toggle-strobed ps2_key event word; strips E0/F0/E1 prefixes.
// Update lands two cycles after the stop-bit fall of the filtered clock is seen.
module ps2_key_gen
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        err
);
    logic [7:0] rx_byte;
    logic       rx_stb;
    logic       rx_err;

    dec_state_t  state_q;
    logic        ext_q, brk_q;
    logic [2:0]  remain_q;
    logic [10:0] key_q;
    logic        dec_err_q;

    ps2_rx_frame #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_rx (
        .clk_i       (clk_sys),
        .rst_n_i     (reset_n),
        .ps2_clk_i   (ps2_clk),
        .ps2_data_i  (ps2_data),
        .byte_o      (rx_byte),
        .byte_stb_o  (rx_stb),
        .frame_err_o (rx_err)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            remain_q  <= '0;
            key_q     <= '0;
            dec_err_q <= 1'b0;
        end else begin
            dec_err_q <= 1'b0;
            if (rx_stb) begin
                if (state_q == ST_PAUSE) begin
                    // Pause has no break code, so only a synthetic make is produced
                    remain_q <= remain_q - 1'b1;
                    if (remain_q == 3'd1) begin
                        key_q   <= {~key_q[10], 1'b1, 1'b1, PAUSE_CODE};
                        state_q <= ST_IDLE;
                    end
                end else if (rx_byte == KEY_E0) begin
                    ext_q   <= 1'b1;
                    state_q <= ST_PREFIX;
                end else if (rx_byte == KEY_F0) begin
                    brk_q   <= 1'b1;
                    state_q <= ST_PREFIX;
                end else if (state_q == ST_IDLE && rx_byte == KEY_E1) begin
                    remain_q <= PAUSE_LEN;
                    state_q  <= ST_PAUSE;
                end else if (state_q == ST_IDLE && is_status(rx_byte)) begin
                    state_q <= ST_IDLE;
                end else begin
                    if (rx_byte == KEY_00 || rx_byte == KEY_FF) begin
                        dec_err_q <= 1'b1;
                    end else if (!(ext_q && rx_byte == FAKE_SHIFT)) begin
                        key_q <= {~key_q[10], ~brk_q, ext_q, rx_byte};
                    end
                    ext_q   <= 1'b0;
                    brk_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            end
        end
    end

    assign ps2_key = key_q;
    assign err     = rx_err | dec_err_q;

endmodule
